// File: rtl/if_fetch_pkg.sv
// Shared widths, the bubble word and a small output-gating helper for the fetch stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package if_fetch_pkg;

  localparam int INST_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_INST = INST_W / BYTE_W;

  // All-zero instruction: ID decodes this as a bubble.
  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  // Byte assembler: element i holds the byte fetched from fetch_pc+i (little-endian).
  typedef logic [BYTES_PER_INST-1:0][BYTE_W-1:0] inst_bytes_t;

  // Presented instruction is forced to the bubble word whenever it is not valid.
  function automatic logic [INST_W-1:0] gate_word(input logic vld, input logic [INST_W-1:0] word);
    return vld ? word : ZERO_WORD;
  endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: four little-endian byte reads per word into a one-entry output register.
// Latency: 2 cycles per byte with 1-cycle memory plus 1 load cycle; first instruction 9 cycles after reset.
// Backpressure: stall_i holds the output register; a finished word waits in DONE; rdy=0 freezes everything.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_valid_i,
  input  logic [7:0]        mem_data_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid_o
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_INST - 1);

  state_e              state_q,     state_d;
  logic [ADDR_W-1:0]   fetch_pc_q,  fetch_pc_d;
  logic [1:0]          byte_cnt_q,  byte_cnt_d;
  logic                drop_q,      drop_d;
  inst_bytes_t         asm_q,       asm_d;
  logic [ADDR_W-1:0]   req_addr_q,  req_addr_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_pc_q,    out_pc_d;
  logic [INST_W-1:0]   out_inst_q,  out_inst_d;

  logic consume;
  logic out_free;

  // State register: every flop only moves when the global ready is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_REQ;
      fetch_pc_q  <= RESET_PC;
      byte_cnt_q  <= '0;
      drop_q      <= 1'b0;
      asm_q       <= '0;
      req_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= ZERO_WORD;
    end else if (rdy) begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      byte_cnt_q  <= byte_cnt_d;
      drop_q      <= drop_d;
      asm_q       <= asm_d;
      req_addr_q  <= req_addr_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
    end
  end

  // Next state: redirect first, then the byte-fetch sequence and the output-register handoff.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    byte_cnt_d  = byte_cnt_q;
    drop_d      = drop_q;
    asm_d       = asm_q;
    req_addr_d  = req_addr_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;

    consume  = out_valid_q && !stall_i;
    out_free = !out_valid_q || !stall_i;

    if (consume) begin
      out_valid_d = 1'b0;
    end

    if (redirect_i) begin
      // Flush: the output and any partial word are discarded, even under stall.
      out_valid_d = 1'b0;
      fetch_pc_d  = redirect_pc_i;
      byte_cnt_d  = '0;
      asm_d       = '0;
      if ((state_q == ST_WAIT) && !mem_valid_i) begin
        // The in-flight byte still has to come back; swallow it before refetching.
        drop_d  = 1'b1;
        state_d = ST_WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = ST_REQ;
      end
    end else begin
      case (state_q)
        ST_REQ: begin
          req_addr_d = fetch_pc_q + ADDR_W'(byte_cnt_q);
          state_d    = ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_valid_i) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = ST_REQ;
            end else begin
              asm_d[byte_cnt_q] = mem_data_i;
              if (byte_cnt_q == LAST_BYTE) begin
                state_d = ST_DONE;
              end else begin
                byte_cnt_d = byte_cnt_q + 2'd1;
                state_d    = ST_REQ;
              end
            end
          end
        end
        ST_DONE: begin
          if (out_free) begin
            out_pc_d    = fetch_pc_q;
            out_inst_d  = asm_q;
            out_valid_d = 1'b1;
            fetch_pc_d  = fetch_pc_q + ADDR_W'(4);
            byte_cnt_d  = '0;
            state_d     = ST_REQ;
          end
        end
        default: begin
          state_d = ST_REQ;
        end
      endcase
    end
  end

  // Outputs: the request is live for the whole WAIT state; invalid output reads as a bubble at pc 0.
  always_comb begin
    mem_req_o    = (state_q == ST_WAIT);
    mem_addr_o   = req_addr_q;
    inst_valid_o = out_valid_q;
    inst_o       = gate_word(out_valid_q, out_inst_q);
    pc_o         = out_valid_q ? out_pc_q : '0;
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a byte memory model of programmable latency.
// Latency: model answers a request after lat extra cycles and holds data until accepted under rdy.
// Backpressure: model keeps mem_valid_i asserted while rdy is low.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_valid_i = 1'b0;
  logic [7:0]  mem_data_i = '0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem [0:511];
  logic [31:0] log_q [$];
  int          lat = 0;
  bit          busy = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = '0;

  if_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_valid_i   (mem_valid_i),
    .mem_data_i    (mem_data_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .inst_valid_o  (inst_valid_o)
  );

  always #5 clk = ~clk;

  // Memory model, evaluated just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      busy = 1'b0;
    end else if (mem_valid_i) begin
      if (rdy) mem_valid_i = 1'b0;
    end else if (busy) begin
      if (cnt == 0) begin
        mem_valid_i = 1'b1;
        mem_data_i  = mem[pend_addr[8:0]];
        busy        = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end else if (mem_req_o) begin
      pend_addr = mem_addr_o;
      log_q.push_back(mem_addr_o);
      if (lat == 0) begin
        mem_valid_i = 1'b1;
        mem_data_i  = mem[pend_addr[8:0]];
      end else begin
        busy = 1'b1;
        cnt  = lat - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int budget, input string tag, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!inst_valid_o && cycles < budget);
    if (!inst_valid_o) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [31:0] exp);
    if (log_q.size() > idx) chk(tag, log_q[idx], exp);
    else chk({tag, "_missing"}, 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    int  idx;
    int  k;
    bit  held;
    logic [31:0] hold_addr;

    for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'hA5;
    {mem[3], mem[2], mem[1], mem[0]}             = 32'h00100513;
    {mem[7], mem[6], mem[5], mem[4]}             = 32'h00200593;
    {mem[11], mem[10], mem[9], mem[8]}           = 32'h00500713;
    {mem[259], mem[258], mem[257], mem[256]}     = 32'h00300613;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req",   {31'd0, mem_req_o}, 32'd0);
    chk("rst_addr",  mem_addr_o, 32'd0);
    chk("rst_pc",    pc_o, 32'd0);
    chk("rst_inst",  inst_o, 32'd0);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);

    // First fetch, presented under stall so it is held
    stall_i = 1'b1;
    rst = 1'b1;
    wait_valid(100, "first", cyc);
    chk("first_lat_min", {31'd0, cyc >= 8}, 32'd1);
    chk("first_pc",   pc_o, 32'h0);
    chk("first_inst", inst_o, 32'h00100513);
    chk_log("first_a0", 0, 32'h0);
    chk_log("first_a1", 1, 32'h1);
    chk_log("first_a2", 2, 32'h2);
    chk_log("first_a3", 3, 32'h3);

    // Stall hold for 20 cycles
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!inst_valid_o || pc_o !== 32'h0 || inst_o !== 32'h00100513) held = 1'b0;
    end
    chk("stall_hold", {31'd0, held}, 32'd1);
    chk("stall_req_count", 32'(log_q.size()), 32'd8);
    chk_log("stall_a7", 7, 32'h7);
    chk("stall_done_idle", {31'd0, mem_req_o}, 32'd0);
    stall_i = 1'b0;
    @(negedge clk);
    chk("second_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("second_pc",   pc_o, 32'h4);
    chk("second_inst", inst_o, 32'h00200593);

    // Redirect while the byte at 9 is outstanding
    lat = 3;
    k = 0;
    while (!(mem_req_o && mem_addr_o == 32'h9 && !mem_valid_i) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("redir_reach_9", {31'd0, mem_req_o && mem_addr_o == 32'h9}, 32'd1);
    idx = log_q.size();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    @(negedge clk);
    redirect_i = 1'b0;
    wait_valid(300, "redir", cyc);
    chk("redir_pc",   pc_o, 32'h100);
    chk("redir_inst", inst_o, 32'h00300613);
    chk_log("redir_next_addr", idx, 32'h100);

    // Redirect beats a stalled valid output
    stall_i = 1'b1;
    lat = 0;
    repeat (3) @(negedge clk);
    idx = log_q.size();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h4;
    @(negedge clk);
    redirect_i = 1'b0;
    chk("rs_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rs_pc",    pc_o, 32'd0);
    chk("rs_inst",  inst_o, 32'd0);
    wait_valid(100, "rs", cyc);
    chk("rs_new_pc",   pc_o, 32'h4);
    chk("rs_new_inst", inst_o, 32'h00200593);
    chk_log("rs_next_addr", idx, 32'h4);

    // rdy low for 5 cycles during WAIT, with the stall released at the same time
    lat = 2;
    k = 0;
    while (!mem_req_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    hold_addr = mem_addr_o;
    rdy = 1'b0;
    stall_i = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!mem_req_o || mem_addr_o !== hold_addr || !inst_valid_o || pc_o !== 32'h4) held = 1'b0;
    end
    chk("rdy_freeze", {31'd0, held}, 32'd1);
    chk("rdy_addr", hold_addr, 32'h8);
    chk("rdy_data_held", {31'd0, mem_valid_i}, 32'd1);
    rdy = 1'b1;
    @(negedge clk);
    chk("rdy_consumed", {31'd0, inst_valid_o}, 32'd0);
    wait_valid(100, "rdy", cyc);
    chk("rdy_pc",   pc_o, 32'h8);
    chk("rdy_inst", inst_o, 32'h00500713);

    // Asynchronous reset between edges with a byte on the bus
    k = 0;
    while (!mem_valid_i && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("arst_pending", {31'd0, mem_valid_i}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req",   {31'd0, mem_req_o}, 32'd0);
    chk("arst_addr",  mem_addr_o, 32'd0);
    chk("arst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("arst_pc",    pc_o, 32'd0);
    chk("arst_inst",  inst_o, 32'd0);
    lat = 0;
    repeat (2) @(negedge clk);
    idx = log_q.size();
    rst = 1'b1;
    wait_valid(100, "arst", cyc);
    chk("arst_refetch_pc",   pc_o, 32'h0);
    chk("arst_refetch_inst", inst_o, 32'h00100513);
    chk_log("arst_a0", idx, 32'h0);
    chk_log("arst_a3", idx + 3, 32'h3);
    @(negedge clk);
    chk("arst_consumed", {31'd0, inst_valid_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. It is the producer side of the IF→ID interface: it supplies the pc/inst pair that ID decodes, and it obeys the ID/EX stall and the EX redirect.
- Fetches 32-bit instructions from the byte-wide memory controller as four sequential byte reads, little-endian.
- Presents fetched instructions through a one-entry output register. An all-zero word is a bubble, and ID decodes it as ZeroOpt.

Parameters:
- RESET_PC, 32'h00000000, fetch address after reset.
- ADDR_W, 32, address width (matches AddrBus).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; low freezes all state.
- stall_i  in  1  downstream stall (id_stall OR'd upstream); output must hold.
- redirect_i  in  1  taken jump/branch from EX; flush and refetch.
- redirect_pc_i  in  ADDR_W  new fetch address.
- mem_req_o  out  1  byte read request.
- mem_addr_o  out  ADDR_W  byte address of the request.
- mem_valid_i  in  1  read data valid; completes the single outstanding request.
- mem_data_i  in  8  returned byte.
- pc_o  out  ADDR_W  pc of the presented instruction (IF_ID pc_i).
- inst_o  out  32  presented instruction (IF_ID inst_i); 0 when invalid.
- inst_valid_o  out  1  pc_o/inst_o hold a real instruction.

Behaviour:
- Reset (rst=0, async) clears state:
  - fetch_pc=RESET_PC, state=REQ, byte_cnt=0, drop=0, out_valid=0.
  - mem_req_o=0, mem_addr_o=0, pc_o=0, inst_o=0, inst_valid_o=0.
- Registered state update only when rst=1 and rdy=1 on rising clk. With rdy=0, every register and output holds.
- FSM states:
  - REQ: drive mem_req_o=1, mem_addr_o=fetch_pc+byte_cnt. Go to WAIT.
  - WAIT: keep mem_req_o=1 and the address stable until mem_valid_i. On mem_valid_i, write mem_data_i into asm[8*byte_cnt+:8].
    - If byte_cnt<3: byte_cnt++ and return to REQ. REQ may re-issue in the same cycle by going straight to WAIT; either way there is one outstanding request at most.
    - If byte_cnt==3: go to DONE.
  - DONE: the assembled word is complete. If the output register is free or being consumed this cycle, load out_pc=fetch_pc and out_inst=asm, then set out_valid=1, fetch_pc+=4, byte_cnt=0, and go to REQ. Otherwise stay in DONE with mem_req_o=0.
- Output consumption:
  - The output is consumed on a cycle where out_valid=1 and stall_i=0.
  - If nothing new is loaded that cycle, out_valid clears the next cycle.
  - With stall_i=1, pc_o and inst_o hold exactly.
  - inst_o=0 and pc_o=0 whenever out_valid=0.
- Redirect (highest priority) in the cycle redirect_i=1:
  - out_valid←0, fetch_pc←redirect_pc_i, byte_cnt←0, any partial asm discarded.
  - If a request is outstanding (state WAIT and no mem_valid_i this cycle): set drop=1 and stay in WAIT. The next mem_valid_i is discarded, drop clears, and the FSM goes to REQ with the new pc.
  - Otherwise go to REQ.
  - redirect_i overrides stall_i and DONE-load in the same cycle.
- Redirect while drop=1 only updates fetch_pc; the later redirect wins.
- Word-aligned addresses are guaranteed by EX. fetch_pc wraps modulo 2^ADDR_W.
- Throughput: ≥8 cycles per instruction with 1-cycle memory. The first inst_valid_o after reset is no earlier than 8 cycles.

Decomposition:
- Shared config header (existing config.v style) holds ADDR_W/AddrBus, InstBus, ZeroWord, Enable/Disable.
- FSM state encodings (REQ, WAIT, DONE) are local to this module.
- No sub-module. The byte assembler is a 4×8 register indexed by byte_cnt.

Test Plan:
- Reset and fetch: memory model with 1-cycle latency, mem[0..3]=13 05 10 00. After reset release → reads at 0,1,2,3 in order, then pc_o=0, inst_o=32'h00100513, inst_valid_o=1.
- Stall hold: keep stall_i=1 for 10 cycles after the first instruction → pc_o and inst_o unchanged; no request issued beyond the next word's 4 bytes. Release the stall → next inst_valid_o carries pc_o=4.
- Redirect mid-word: assert redirect_i, redirect_pc_i=32'h100 while the byte at addr 5 is outstanding → returned byte discarded; next request addr=32'h100; inst_valid_o=0 until the word at 0x100 is presented.
- Redirect with valid output and stall_i=1 in the same cycle → inst_valid_o=0 next cycle, and the fetch restarts at redirect_pc_i.
- rdy gating: drop rdy for 5 cycles during WAIT, with the memory model holding data → no state change, mem_addr_o stable, completes correctly after rdy=1.
- Async reset mid-fetch: pull rst low between clock edges → outputs are 0 immediately. After release, fetch restarts at RESET_PC=0 and a late mem_valid_i is ignored.
